// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
package dmem_arb_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int LINE_W_DEF = 256;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY    = 2'd1,
    ST_RELEASE = 2'd2
  } arb_state_e;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_P0   = 2'b01;
  localparam logic [1:0] GRANT_P1   = 2'b10;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Combinational two-way round-robin picker: on contention the port that
// did not win last time is chosen.
module rr_arb2
  import dmem_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_ptr_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = GRANT_NONE;
    if (req_i == 2'b11) begin
      gnt_o = last_ptr_i ? GRANT_P0 : GRANT_P1;
    end else if (req_i[0]) begin
      gnt_o = GRANT_P0;
    end else if (req_i[1]) begin
      gnt_o = GRANT_P1;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one line-wide data-memory port between the I-cache (port 0) and
// D-cache (port 1) refill engines, with a sticky no-ack watchdog.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter int LINE_W         = LINE_W_DEF,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              p0_enable_i,
  input  logic              p0_write_i,
  input  logic [ADDR_W-1:0] p0_addr_i,
  input  logic [LINE_W-1:0] p0_data_i,
  output logic [LINE_W-1:0] p0_data_o,
  output logic              p0_ack_o,
  input  logic              p1_enable_i,
  input  logic              p1_write_i,
  input  logic [ADDR_W-1:0] p1_addr_i,
  input  logic [LINE_W-1:0] p1_data_i,
  output logic [LINE_W-1:0] p1_data_o,
  output logic              p1_ack_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [LINE_W-1:0] mem_data_o,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic              mem_ack_i,
  output logic [1:0]        grant_o,
  output logic              err_o
);

  // Handshake: a requester raises pX_enable_i and holds it (with stable
  // command) until pX_ack_o pulses; the memory holds mem_enable_o high
  // until it returns a single-cycle mem_ack_i.

  arb_state_e        state_q, state_d;
  logic [1:0]        grant_q, grant_d;
  logic              last_q, last_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_wr_q, mem_wr_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [LINE_W-1:0] mem_data_q, mem_data_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;
  logic [1:0]        pick;

  rr_arb2 u_rr (
    .req_i      ({p1_enable_i, p0_enable_i}),
    .last_ptr_i (last_q),
    .gnt_o      (pick)
  );

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    last_d     = last_q;
    mem_en_d   = mem_en_q;
    mem_wr_d   = mem_wr_q;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    case (state_q)
      ST_IDLE: begin
        if (pick != GRANT_NONE) begin
          state_d    = ST_BUSY;
          grant_d    = pick;
          last_d     = pick[1];
          mem_en_d   = 1'b1;
          mem_wr_d   = pick[1] ? p1_write_i : p0_write_i;
          mem_addr_d = pick[1] ? p1_addr_i  : p0_addr_i;
          mem_data_d = pick[1] ? p1_data_i  : p0_data_i;
          cnt_d      = '0;
        end
      end
      ST_BUSY: begin
        if (mem_ack_i) begin
          state_d  = ST_RELEASE;
          grant_d  = GRANT_NONE;
          mem_en_d = 1'b0;
          mem_wr_d = 1'b0;
        end else begin
          if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
          // The transaction is never aborted; the watchdog only reports.
          if ((TIMEOUT_CYCLES != 0) && (cnt_d == CNT_W'(TIMEOUT_CYCLES))) err_d = 1'b1;
        end
      end
      ST_RELEASE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      grant_q    <= GRANT_NONE;
      last_q     <= 1'b1;
      mem_en_q   <= 1'b0;
      mem_wr_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      last_q     <= last_d;
      mem_en_q   <= mem_en_d;
      mem_wr_q   <= mem_wr_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    p0_ack_o  = (state_q == ST_BUSY) && mem_ack_i && grant_q[0];
    p1_ack_o  = (state_q == ST_BUSY) && mem_ack_i && grant_q[1];
    p0_data_o = p0_ack_o ? mem_data_i : '0;
    p1_data_o = p1_ack_o ? mem_data_i : '0;
  end

  assign mem_enable_o = mem_en_q;
  assign mem_write_o  = mem_wr_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_data_o   = mem_data_q;
  assign grant_o      = grant_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed + randomized bench for dmem_arbiter against a cycle reference
// model of the arbitration rules.
module tb_dmem_arbiter;

  localparam int ADDR_W  = 32;
  localparam int LINE_W  = 256;
  localparam int TIMEOUT = 64;

  logic              clk = 1'b0;
  logic              rst;
  logic              en0, w0, en1, w1, mem_ack;
  logic [ADDR_W-1:0] a0, a1;
  logic [LINE_W-1:0] d0, d1, mem_rd;
  logic [LINE_W-1:0] p0_data_o, p1_data_o, mem_data_o;
  logic              p0_ack_o, p1_ack_o, mem_enable_o, mem_write_o, err_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [1:0]        grant_o;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .TIMEOUT_CYCLES(TIMEOUT), .CNT_W(8)) dut (
    .clk_i(clk), .rst_i(rst),
    .p0_enable_i(en0), .p0_write_i(w0), .p0_addr_i(a0), .p0_data_i(d0),
    .p0_data_o(p0_data_o), .p0_ack_o(p0_ack_o),
    .p1_enable_i(en1), .p1_write_i(w1), .p1_addr_i(a1), .p1_data_i(d1),
    .p1_data_o(p1_data_o), .p1_ack_o(p1_ack_o),
    .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o),
    .mem_data_o(mem_data_o), .mem_data_i(mem_rd), .mem_ack_i(mem_ack),
    .grant_o(grant_o), .err_o(err_o)
  );

  // Reference model: phase 0 idle, 1 owned by m_owner, 2 release gap.
  int                checks = 0;
  int                errors = 0;
  int                m_phase, m_owner, m_last, m_wd, age, lat;
  logic              m_err, m_wr, ack0_seen, ack1_seen, want0, want1, rand_data, rec_on;
  logic [ADDR_W-1:0] m_addr;
  logic [LINE_W-1:0] m_data, fixed_rd;
  logic [1:0]        obs_q[$];
  logic [1:0]        exp_q[$];

  task automatic chk(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [LINE_W-1:0] rand_line();
    logic [LINE_W-1:0] v;
    for (int i = 0; i < LINE_W / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_owner = 0; m_last = 1; m_wd = 0; m_err = 1'b0;
    m_wr = 1'b0; m_addr = '0; m_data = '0;
  endtask

  // Checks combinational outputs for current inputs, advances the model,
  // clocks the DUT and checks the registered outputs.
  task automatic tick();
    logic e0, e1;
    int   prev_phase;
    #1;
    e0 = !rst && (m_phase == 1) && (m_owner == 0) && mem_ack;
    e1 = !rst && (m_phase == 1) && (m_owner == 1) && mem_ack;
    chk("p0_ack", LINE_W'(p0_ack_o), LINE_W'(e0));
    chk("p1_ack", LINE_W'(p1_ack_o), LINE_W'(e1));
    chk("p0_data", p0_data_o, e0 ? mem_rd : '0);
    chk("p1_data", p1_data_o, e1 ? mem_rd : '0);
    ack0_seen = e0; ack1_seen = e1;
    prev_phase = m_phase;
    if (rst) model_reset();
    else if (m_phase == 0) begin
      if (en0 || en1) begin
        m_owner = (en0 && en1) ? 1 - m_last : (en0 ? 0 : 1);
        m_last  = m_owner;
        m_wr    = m_owner ? w1 : w0;
        m_addr  = m_owner ? a1 : a0;
        m_data  = m_owner ? d1 : d0;
        m_wd    = 0;
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      if (mem_ack) begin
        m_phase = 2; m_wr = 1'b0;
      end else begin
        if (m_wd < 255) m_wd++;
        if (TIMEOUT != 0 && m_wd == TIMEOUT) m_err = 1'b1;
      end
    end else m_phase = 0;
    @(posedge clk);
    #1;
    chk("mem_enable", LINE_W'(mem_enable_o), LINE_W'(m_phase == 1));
    chk("mem_write", LINE_W'(mem_write_o), LINE_W'(m_wr));
    chk("mem_addr", LINE_W'(mem_addr_o), LINE_W'(m_addr));
    chk("mem_data", mem_data_o, m_data);
    chk("grant", LINE_W'(grant_o), (m_phase == 1) ? LINE_W'(m_owner ? 2'b10 : 2'b01) : '0);
    chk("err", LINE_W'(err_o), LINE_W'(m_err));
    if (rec_on && prev_phase != 1 && m_phase == 1) obs_q.push_back(grant_o);
  endtask

  // Cycle driver: requesters hold enable while they want service; memory
  // acks after a latency chosen in [lo,hi] BUSY cycles.
  task automatic run(input int n, input bit hold, input bit jitter0, input bit rnd_req,
                     input int lo, input int hi);
    for (int c = 0; c < n; c++) begin
      if (rnd_req) begin
        if (!want0 && $urandom_range(0, 2) == 0) begin
          want0 = 1'b1; w0 = $urandom; a0 = {$urandom, 5'b0}; d0 = rand_line();
        end
        if (!want1 && $urandom_range(0, 2) == 0) begin
          want1 = 1'b1; w1 = $urandom; a1 = {$urandom, 5'b0}; d1 = rand_line();
        end
      end
      en0 = want0; en1 = want1;
      if (jitter0 && m_phase != 0) begin
        en0 = $urandom; w0 = $urandom; a0 = {$urandom, 5'b0}; d0 = rand_line();
      end
      if (m_phase == 1) begin
        mem_ack = (age >= lat);
        age++;
      end else begin
        mem_ack = rnd_req ? ($urandom_range(0, 3) == 0) : 1'b0;
        age = 0;
        lat = $urandom_range(lo, hi);
      end
      mem_rd = rand_data ? rand_line() : fixed_rd;
      tick();
      if (ack0_seen && !hold) want0 = 1'b0;
      if (ack1_seen && !hold) want1 = 1'b0;
    end
  endtask

  task automatic quiet_inputs();
    en0 = 0; w0 = 0; a0 = '0; d0 = '0; want0 = 0;
    en1 = 0; w1 = 0; a1 = '0; d1 = '0; want1 = 0;
    mem_ack = 0; mem_rd = '0;
  endtask

  initial begin
    logic [LINE_W-1:0] a5_line;
    a5_line = {(LINE_W / 8){8'hA5}};
    rec_on = 0; rand_data = 0; fixed_rd = '0; age = 0; lat = 0;
    quiet_inputs();
    model_reset();
    rst = 1;
    tick(); tick();
    rst = 0;
    chk("reset_grant", LINE_W'(grant_o), '0);

    // Lone port-0 read, ack 10 BUSY cycles later with A5 data.
    fixed_rd = a5_line;
    want0 = 1; w0 = 0; a0 = 32'h0000_0100;
    run(16, 0, 0, 0, 10, 10);
    quiet_inputs();
    run(2, 0, 0, 0, 1, 1);

    // Fresh reset, then continuous dual requests: grants must alternate.
    rst = 1; tick(); rst = 0;
    rand_data = 1;
    want0 = 1; want1 = 1; a0 = 32'h0000_0200; a1 = 32'h0000_0400;
    d0 = rand_line(); d1 = rand_line();
    exp_q = '{2'b01, 2'b10, 2'b01, 2'b10};
    obs_q.delete();
    rec_on = 1;
    run(4 * 6 + 2, 1, 0, 0, 3, 3);
    rec_on = 0;
    for (int i = 0; i < 4; i++) chk("grant_seq", LINE_W'(obs_q[i]), LINE_W'(exp_q[i]));
    quiet_inputs();
    run(4, 0, 0, 0, 1, 1);

    // Port-1 write while port 0 jitters its inputs during BUSY.
    want1 = 1; w1 = 1; a1 = 32'h0000_3FE0; d1 = {(LINE_W / 16){16'h1234}};
    run(14, 0, 1, 0, 8, 8);
    quiet_inputs();
    run(3, 0, 0, 0, 1, 1);

    // Watchdog: ack withheld for 70 BUSY cycles, then a late ack.
    want0 = 1; a0 = 32'h0000_0800;
    run(76, 0, 0, 0, 70, 70);
    chk("err_sticky", LINE_W'(err_o), LINE_W'(1'b1));
    quiet_inputs();
    run(3, 0, 0, 0, 1, 1);

    // Reset mid-BUSY, then a stray ack, then dual request -> port 0.
    want1 = 1; a1 = 32'h0000_1000;
    run(4, 0, 0, 0, 20, 20);
    rst = 1; tick(); rst = 0;
    quiet_inputs();
    mem_ack = 1; tick(); mem_ack = 0;
    en0 = 1; en1 = 1; a0 = 32'h0000_0040; a1 = 32'h0000_0060; tick();
    chk("post_reset_p0", LINE_W'(grant_o), LINE_W'(2'b01));
    want0 = 1; want1 = 1;
    run(8, 0, 0, 0, 2, 2);
    quiet_inputs();
    run(3, 0, 0, 0, 1, 1);

    // Stray ack while idle with no requesters.
    mem_ack = 1; mem_rd = rand_line(); tick();
    mem_ack = 0; tick();

    // Randomized traffic with random latencies and stray acks.
    run(600, 0, 0, 1, 0, 6);
    quiet_inputs();
    run(12, 0, 0, 0, 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
